// File: rtl/multicycle_control_fsm_if.sv
interface multicycle_control_fsm_if #(
  parameter int unsigned STATE_W = 4
);
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               zero;
  logic [1:0]         immsrc;
  logic [1:0]         alusrca;
  logic [1:0]         alusrcb;
  logic [2:0]         alucontrol;
  logic [1:0]         resultsrc;
  logic               adrsrc;
  logic               irwrite;
  logic               pcwrite;
  logic               regwrite;
  logic               memwrite;
  logic               instr_done;
  logic               illegal_op;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op, funct3, funct7b5, zero,
    output immsrc, alusrca, alusrcb, alucontrol, resultsrc, adrsrc,
           irwrite, pcwrite, regwrite, memwrite, instr_done, illegal_op, state_o
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  immsrc, alusrca, alusrcb, alucontrol, resultsrc, adrsrc,
           irwrite, pcwrite, regwrite, memwrite, instr_done, illegal_op, state_o
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
module multicycle_control_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_control_fsm_if.master bus
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 0,
    DECODE   = 1,
    MEMADR   = 2,
    MEMREAD  = 3,
    MEMWB    = 4,
    MEMWRITE = 5,
    EXECUTER = 6,
    EXECUTEI = 7,
    ALUWB    = 8,
    BEQ      = 9,
    JAL      = 10
  } state_t;

  state_t     state;
  state_t     next;
  state_t     cur;
  logic       pcupdate;
  logic       branch;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next;
  end

  // While rst is high the outputs decode as FETCH, then every enable is masked.
  always_comb begin
    next             = FETCH;
    pcupdate         = 1'b0;
    branch           = 1'b0;
    aluop            = 2'b00;
    bus.alusrca      = 2'b00;
    bus.alusrcb      = 2'b00;
    bus.resultsrc    = 2'b00;
    bus.adrsrc       = 1'b0;
    bus.irwrite      = 1'b0;
    bus.regwrite     = 1'b0;
    bus.memwrite     = 1'b0;
    bus.instr_done   = 1'b0;
    bus.illegal_op   = 1'b0;
    cur              = rst ? FETCH : state;
    case (cur)
      FETCH: begin
        bus.irwrite   = 1'b1;
        pcupdate      = 1'b1;
        bus.alusrcb   = 2'b10;
        bus.resultsrc = 2'b10;
        next          = DECODE;
      end
      DECODE: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXECUTER;
          OP_I:         next = EXECUTEI;
          OP_BEQ:       next = BEQ;
          OP_JAL:       next = JAL;
          default: begin
            next           = FETCH;
            bus.illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
        next        = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.adrsrc = 1'b1;
        next       = MEMWB;
      end
      MEMWB: begin
        bus.resultsrc  = 2'b01;
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      MEMWRITE: begin
        bus.adrsrc     = 1'b1;
        bus.memwrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      EXECUTER: begin
        bus.alusrca = 2'b10;
        aluop       = 2'b10;
        next        = ALUWB;
      end
      EXECUTEI: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
        aluop       = 2'b10;
        next        = ALUWB;
      end
      ALUWB: begin
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      BEQ: begin
        bus.alusrca    = 2'b10;
        aluop          = 2'b01;
        branch         = 1'b1;
        bus.instr_done = 1'b1;
      end
      JAL: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b10;
        pcupdate    = 1'b1;
        next        = ALUWB;
      end
      default: next = FETCH;
    endcase
    bus.pcwrite = ~rst & (pcupdate | (branch & bus.zero));
    if (rst) begin
      bus.irwrite    = 1'b0;
      bus.regwrite   = 1'b0;
      bus.memwrite   = 1'b0;
      bus.instr_done = 1'b0;
      bus.illegal_op = 1'b0;
    end
  end

  always_comb begin
    case (bus.op)
      OP_SW:   bus.immsrc = 2'b01;
      OP_BEQ:  bus.immsrc = 2'b10;
      OP_JAL:  bus.immsrc = 2'b11;
      default: bus.immsrc = 2'b00;
    endcase
  end

  always_comb begin
    bus.alucontrol = 3'b000;
    case (aluop)
      2'b00: bus.alucontrol = 3'b000;
      2'b01: bus.alucontrol = 3'b001;
      default: begin
        case (bus.funct3)
          3'b000:  bus.alucontrol = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  bus.alucontrol = 3'b101;
          3'b110:  bus.alucontrol = 3'b011;
          3'b111:  bus.alucontrol = 3'b010;
          default: bus.alucontrol = 3'b000;
        endcase
      end
    endcase
  end

  assign bus.state_o = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_fsm_if #(.STATE_W(4)) bus ();

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // per-state expected controls: irw pcu br rw mw dn adr | alusrca alusrcb resultsrc aluop
  typedef struct packed {
    logic irw, pcu, br, rw, mw, dn, adr;
    logic [1:0] a, b, rs, aop;
  } exp_t;
  exp_t tbl [0:10];

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [31:0] code;
    int unsigned len;
    logic [1:0]  imm;
    logic        alu_chk;
    logic [2:0]  alu;
    int unsigned pcw_idx;
    logic        pcw;
    logic        done_last;
    logic        ill;
  } vec_t;
  vec_t vecs [$];

  int unsigned idx = 0;
  logic        started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] path_code(input logic [6:0] o);
    case (o)
      7'b0000011: return 32'h43210;
      7'b0100011: return 32'h5210;
      7'b0110011: return 32'h8610;
      7'b0010011: return 32'h8710;
      7'b1100011: return 32'h910;
      7'b1101111: return 32'h8A10;
      default:    return 32'h10;
    endcase
  endfunction

  function automatic int unsigned path_len(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b1100011: return 3;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      default:    return 2;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] exp_alu(input logic [1:0] aop, input logic [2:0] f3,
                                         input logic f7, input logic op5);
    if (aop == 2'b00) return 3'b000;
    if (aop == 2'b01) return 3'b001;
    case (f3)
      3'b000:  return {2'b00, op5 & f7};
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[4]  = '{0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b00};
    tbl[5]  = '{0, 0, 0, 0, 1, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10};
    tbl[8]  = '{0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[9]  = '{0, 0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 2'b01};
    tbl[10] = '{0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00};
  end

  // model position within the current instruction's state path
  always @(posedge clk) begin
    if (rst) begin
      started <= 1'b1;
      idx     <= 0;
    end else begin
      idx <= (idx + 1 == path_len(bus.op)) ? 0 : idx + 1;
    end
  end

  // cycle-by-cycle comparison against the model
  always @(negedge clk) begin : cmp
    exp_t        e;
    logic [31:0] code;
    logic [3:0]  es;
    logic        ill;
    if (started) begin
      code = path_code(bus.op);
      es   = code[4*idx +: 4];
      if (rst) begin
        e     = tbl[0];
        e.irw = 1'b0;
        e.pcu = 1'b0;
        ill   = 1'b0;
      end else begin
        e   = tbl[es];
        ill = (es == 4'd1) && (path_len(bus.op) == 2);
        check("state_o", 32'(bus.state_o), 32'(es));
      end
      check("irwrite",    32'(bus.irwrite),    32'(e.irw));
      check("pcwrite",    32'(bus.pcwrite),    32'(e.pcu | (e.br & bus.zero)));
      check("regwrite",   32'(bus.regwrite),   32'(e.rw));
      check("memwrite",   32'(bus.memwrite),   32'(e.mw));
      check("instr_done", 32'(bus.instr_done), 32'(e.dn));
      check("illegal_op", 32'(bus.illegal_op), 32'(ill));
      check("adrsrc",     32'(bus.adrsrc),     32'(e.adr));
      check("alusrca",    32'(bus.alusrca),    32'(e.a));
      check("alusrcb",    32'(bus.alusrcb),    32'(e.b));
      check("resultsrc",  32'(bus.resultsrc),  32'(e.rs));
      check("immsrc",     32'(bus.immsrc),     32'(exp_imm(bus.op)));
      check("alucontrol", 32'(bus.alucontrol),
            32'(exp_alu(e.aop, bus.funct3, bus.funct7b5, bus.op[5])));
    end
  end

  task automatic run_vec(input vec_t v);
    logic [31:0] code;
    code         = v.code;
    bus.op       = v.op;
    bus.funct3   = v.f3;
    bus.funct7b5 = v.f7;
    bus.zero     = v.z;
    for (int unsigned i = 0; i < v.len; i++) begin
      @(negedge clk);
      check("vec_state", 32'(bus.state_o), 32'(code[4*i +: 4]));
      if (i == 0) begin
        check("vec_immsrc",  32'(bus.immsrc),  32'(v.imm));
        check("vec_irwrite", 32'(bus.irwrite), 32'd1);
      end
      if (i == 1) check("vec_illegal", 32'(bus.illegal_op), 32'(v.ill));
      if (i == 2 && v.alu_chk) check("vec_alucontrol", 32'(bus.alucontrol), 32'(v.alu));
      if (i == v.pcw_idx) check("vec_pcwrite", 32'(bus.pcwrite), 32'(v.pcw));
      if (i == v.len - 1) check("vec_done", 32'(bus.instr_done), 32'(v.done_last));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    //                op          f3      f7 z  code        len imm   chk alu     pidx pcw done ill
    vecs.push_back('{7'b0000011, 3'b010, 0, 0, 32'h43210, 5, 2'b00, 0, 3'b000, 4, 0, 1, 0});
    vecs.push_back('{7'b0100011, 3'b010, 0, 0, 32'h5210,  4, 2'b01, 0, 3'b000, 3, 0, 1, 0});
    vecs.push_back('{7'b0110011, 3'b000, 1, 0, 32'h8610,  4, 2'b00, 1, 3'b001, 3, 0, 1, 0});
    vecs.push_back('{7'b0010011, 3'b000, 1, 0, 32'h8710,  4, 2'b00, 1, 3'b000, 3, 0, 1, 0});
    vecs.push_back('{7'b0110011, 3'b000, 0, 0, 32'h8610,  4, 2'b00, 1, 3'b000, 3, 0, 1, 0});
    vecs.push_back('{7'b0110011, 3'b110, 0, 0, 32'h8610,  4, 2'b00, 1, 3'b011, 3, 0, 1, 0});
    vecs.push_back('{7'b0110011, 3'b111, 0, 0, 32'h8610,  4, 2'b00, 1, 3'b010, 3, 0, 1, 0});
    vecs.push_back('{7'b0010011, 3'b010, 0, 0, 32'h8710,  4, 2'b00, 1, 3'b101, 3, 0, 1, 0});
    vecs.push_back('{7'b1100011, 3'b000, 0, 1, 32'h910,   3, 2'b10, 1, 3'b001, 2, 1, 1, 0});
    vecs.push_back('{7'b1100011, 3'b000, 0, 0, 32'h910,   3, 2'b10, 1, 3'b001, 2, 0, 1, 0});
    vecs.push_back('{7'b1101111, 3'b000, 0, 0, 32'h8A10,  4, 2'b11, 0, 3'b000, 2, 1, 1, 0});
    vecs.push_back('{7'b1111111, 3'b000, 0, 0, 32'h10,    2, 2'b00, 0, 3'b000, 1, 0, 0, 1});

    bus.op       = 7'b0000011;
    bus.funct3   = 3'b010;
    bus.funct7b5 = 1'b0;
    bus.zero     = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_pcwrite", 32'(bus.pcwrite), 32'd0);
    check("rst_irwrite", 32'(bus.irwrite), 32'd0);
    check("rst_state",   32'(bus.state_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k]);

    // reset asserted while the store is in MEMWRITE
    bus.op     = 7'b0100011;
    bus.funct3 = 3'b010;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_state", 32'(bus.state_o), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    check("rst_memwrite",   32'(bus.memwrite),   32'd0);
    check("rst_instr_done", 32'(bus.instr_done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_state", 32'(bus.state_o), 32'd0);

    run_vec(vecs[0]);
    run_vec(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
